// File: rtl/serial_link_physical_rx_os.sv
// Oversampling receiver for the forwarded-clock serial link: synchronizes clock and lanes
// with clk_i, reassembles SDR/DDR words on forwarded-clock edges and buffers them in a FIFO.
module serial_link_physical_rx_os #(
  parameter int NumLanes    = 8,
  parameter int EnDdr       = 1,
  parameter int SyncStages  = 2,
  parameter int FifoDepth   = 8,
  parameter int IdleTimeout = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                ddr_rcv_clk_i,
  input  logic [NumLanes-1:0]                 ddr_i,
  output logic [NumLanes*(1+EnDdr)-1:0]       data_o,
  output logic                                data_valid_o,
  input  logic                                data_ready_i,
  output logic [$clog2(FifoDepth):0]          fill_o,
  output logic                                overflow_o,
  input  logic                                clear_overflow_i,
  output logic                                link_active_o
);

  localparam int WordW = NumLanes * (1 + EnDdr);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int FillW = PtrW + 1;
  localparam int CntW  = $clog2(IdleTimeout + 1);

  logic [SyncStages-1:0] clk_sync_r;
  logic [NumLanes-1:0]   lane_sync_r [SyncStages];
  logic                  clk_s;
  logic [NumLanes-1:0]   lanes_s;
  logic                  prev_r;
  logic                  rise_s;
  logic                  fall_s;
  logic                  edge_s;
  logic                  rise_r;
  logic                  fall_r;
  logic [NumLanes-1:0]   lanes_r;
  logic [CntW-1:0]       cnt_r;
  logic [CntW-1:0]       cnt_nxt_s;
  logic                  idle_s;
  logic                  link_r;
  logic                  link_nxt_s;
  logic                  push_s;
  logic [WordW-1:0]      word_s;
  logic                  push_r;
  logic [WordW-1:0]      word_r;
  logic [WordW-1:0]      mem_r [FifoDepth];
  logic [PtrW-1:0]       wptr_r;
  logic [PtrW-1:0]       rptr_r;
  logic [FillW-1:0]      fill_r;
  logic [FillW-1:0]      fill_nxt_s;
  logic                  valid_r;
  logic                  ovf_r;
  logic                  full_s;
  logic                  pop_s;
  logic                  wr_s;
  logic                  drop_s;

  // Equal-depth synchronizer chains keep sampled lanes aligned with the sampled clock
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_r <= {SyncStages{1'b1}};
      for (int i = 0; i < SyncStages; i++) lane_sync_r[i] <= {NumLanes{1'b0}};
    end else begin
      clk_sync_r     <= {clk_sync_r[SyncStages-2:0], ddr_rcv_clk_i};
      lane_sync_r[0] <= ddr_i;
      for (int i = 1; i < SyncStages; i++) lane_sync_r[i] <= lane_sync_r[i-1];
    end
  end

  assign clk_s   = clk_sync_r[SyncStages-1];
  assign lanes_s = lane_sync_r[SyncStages-1];
  assign rise_s  = clk_s & ~prev_r;
  assign fall_s  = ~clk_s & prev_r;
  assign edge_s  = rise_s | fall_s;

  // Edge history plus one aligned stage of edge flags and lane data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_r  <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      lanes_r <= {NumLanes{1'b0}};
    end else begin
      prev_r  <= clk_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      lanes_r <= lanes_s;
    end
  end

  assign idle_s = (cnt_r == CntW'(IdleTimeout));

  // Idle counter clears on any edge and saturates at the timeout
  always_comb begin
    cnt_nxt_s  = cnt_r;
    link_nxt_s = link_r;
    if (edge_s) begin
      cnt_nxt_s  = {CntW{1'b0}};
      link_nxt_s = 1'b1;
    end else begin
      if (idle_s) cnt_nxt_s = cnt_r;
      else        cnt_nxt_s = cnt_r + CntW'(1);
      if (cnt_nxt_s == CntW'(IdleTimeout)) link_nxt_s = 1'b0;
      else                                 link_nxt_s = link_r;
    end
  end

  // Idle counter and link-activity flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r  <= {CntW{1'b0}};
      link_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      link_r <= link_nxt_s;
    end
  end

  if (EnDdr != 0) begin : g_ddr
    typedef enum logic [0:0] {WAIT_LO = 1'b0, HAVE_LO = 1'b1} asm_state_e;
    asm_state_e          state_r;
    asm_state_e          state_nxt_s;
    logic                lo_load_s;
    logic [NumLanes-1:0] lo_r;

    // Assembly state register
    always_ff @(posedge clk_i) begin
      if (rst_i) state_r <= WAIT_LO;
      else       state_r <= state_nxt_s;
    end

    // Timeout abandons a half word; otherwise falls arm and rises complete
    always_comb begin
      state_nxt_s = state_r;
      if (idle_s) begin
        state_nxt_s = WAIT_LO;
      end else begin
        case (state_r)
          WAIT_LO: state_nxt_s = fall_r ? HAVE_LO : WAIT_LO;
          HAVE_LO: state_nxt_s = rise_r ? WAIT_LO : HAVE_LO;
          default: state_nxt_s = WAIT_LO;
        endcase
      end
    end

    // Assembly outputs: lo capture and word push
    always_comb begin
      push_s    = 1'b0;
      lo_load_s = 1'b0;
      case (state_r)
        WAIT_LO: lo_load_s = fall_r;
        HAVE_LO: begin
          push_s    = rise_r;
          lo_load_s = fall_r;
        end
        default: begin
          push_s    = 1'b0;
          lo_load_s = 1'b0;
        end
      endcase
    end

    // Falling-edge half-word holder
    always_ff @(posedge clk_i) begin
      if (rst_i)          lo_r <= {NumLanes{1'b0}};
      else if (lo_load_s) lo_r <= lanes_r;
      else                lo_r <= lo_r;
    end

    assign word_s = {lanes_r, lo_r};
  end else begin : g_sdr
    assign push_s = rise_r;
    assign word_s = lanes_r;
  end

  // Registered hand-off from assembly into the FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      push_r <= 1'b0;
      word_r <= {WordW{1'b0}};
    end else begin
      push_r <= push_s;
      word_r <= word_s;
    end
  end

  assign full_s = (fill_r == FillW'(FifoDepth));
  assign pop_s  = valid_r & data_ready_i;
  assign wr_s   = push_r & (~full_s | pop_s);
  assign drop_s = push_r & full_s & ~pop_s;

  // Occupancy update
  always_comb begin
    fill_nxt_s = fill_r;
    case ({wr_s, pop_s})
      2'b10:   fill_nxt_s = fill_r + FillW'(1);
      2'b01:   fill_nxt_s = fill_r - FillW'(1);
      default: fill_nxt_s = fill_r;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) mem_r[i] <= {WordW{1'b0}};
      wptr_r  <= {PtrW{1'b0}};
      rptr_r  <= {PtrW{1'b0}};
      fill_r  <= {FillW{1'b0}};
      valid_r <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wptr_r] <= word_r;
        wptr_r        <= wptr_r + PtrW'(1);
      end
      if (pop_s) rptr_r <= rptr_r + PtrW'(1);
      fill_r  <= fill_nxt_s;
      valid_r <= (fill_nxt_s != {FillW{1'b0}});
    end
  end

  // Sticky overflow; a new drop wins over a clear
  always_ff @(posedge clk_i) begin
    if (rst_i)                 ovf_r <= 1'b0;
    else if (drop_s)           ovf_r <= 1'b1;
    else if (clear_overflow_i) ovf_r <= 1'b0;
    else                       ovf_r <= ovf_r;
  end

  assign data_o        = mem_r[rptr_r];
  assign data_valid_o  = valid_r;
  assign fill_o        = fill_r;
  assign overflow_o    = ovf_r;
  assign link_active_o = link_r;

endmodule

// File: tb/tb_serial_link_physical_rx_os.sv
// Directed bench for serial_link_physical_rx_os: DDR and SDR instances, queue scoreboards
// checked by negedge monitors at every valid & ready handshake.
module tb_serial_link_physical_rx_os;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fclk = 1'b1;
  logic [7:0]  lanes = 8'h00;
  logic [15:0] data;
  logic        valid;
  logic        ready = 1'b0;
  logic [3:0]  fill;
  logic        ovf;
  logic        clr = 1'b0;
  logic        link;

  logic        s_fclk = 1'b1;
  logic [7:0]  s_lanes = 8'h00;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready = 1'b1;
  logic [3:0]  s_fill;
  logic        s_ovf;
  logic        s_link;

  int checks = 0;
  int failures = 0;
  int sdr_words = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  s_q[$];
  logic [15:0] e16;
  logic [7:0]  e8;

  serial_link_physical_rx_os #(.NumLanes(8), .EnDdr(1)) dut (
    .clk_i(clk), .rst_i(rst), .ddr_rcv_clk_i(fclk), .ddr_i(lanes),
    .data_o(data), .data_valid_o(valid), .data_ready_i(ready), .fill_o(fill),
    .overflow_o(ovf), .clear_overflow_i(clr), .link_active_o(link));

  serial_link_physical_rx_os #(.NumLanes(8), .EnDdr(0)) dut_sdr (
    .clk_i(clk), .rst_i(rst), .ddr_rcv_clk_i(s_fclk), .ddr_i(s_lanes),
    .data_o(s_data), .data_valid_o(s_valid), .data_ready_i(s_ready), .fill_o(s_fill),
    .overflow_o(s_ovf), .clear_overflow_i(1'b0), .link_active_o(s_link));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One DDR word: low byte on the falling phase, high byte on the rising phase
  task automatic ddr_word(input logic [7:0] hi, input logic [7:0] lo, input bit lat);
    logic [3:0] f0;
    fclk = 1'b0; lanes = lo;
    tick(4);
    fclk = 1'b1; lanes = hi;
    f0 = fill;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (lat && k == 3) chk("latency_before", fill, f0);
      if (lat && k == 4) chk("latency_at", fill, f0 + 4'd1);
    end
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int i = 0; i < 40 && fill != 4'd0; i++) tick(1);
    chk(name, fill, 4'd0);
    ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL ddr_unexpected_word actual=%h expected=none", data);
      end else begin
        e16 = exp_q.pop_front();
        chk("ddr_word", data, e16);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) begin
      sdr_words++;
      if (s_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sdr_unexpected_word actual=%h expected=none", s_data);
      end else begin
        e8 = s_q.pop_front();
        chk("sdr_word", s_data, e8);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_fill", fill, 4'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_link", link, 1'b0);
    chk("rst_data", data, 16'h0000);
    rst = 1'b0;
    tick(2);

    // Two DDR words with latency checks
    exp_q.push_back(16'hA55A);
    ddr_word(8'hA5, 8'h5A, 1'b1);
    exp_q.push_back(16'h1234);
    ddr_word(8'h12, 8'h34, 1'b1);
    chk("t1_link", link, 1'b1);
    drain("t1_fill_zero");

    // Lone falling edge, timeout, discarded rise, then a full word
    fclk = 1'b0; lanes = 8'h77;
    tick(4);
    chk("t2_link_up", link, 1'b1);
    tick(80);
    chk("t2_link_down", link, 1'b0);
    fclk = 1'b1; lanes = 8'h99;
    tick(6);
    chk("t2_no_partial", fill, 4'd0);
    exp_q.push_back(16'hBEEF);
    ddr_word(8'hBE, 8'hEF, 1'b1);
    drain("t2_fill_zero");

    // Overflow: ten words into eight entries
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back({8'h10 + 8'(i), 8'h80 + 8'(i)});
      ddr_word(8'h10 + 8'(i), 8'h80 + 8'(i), 1'b0);
    end
    chk("t3_fill_full", fill, 4'd8);
    chk("t3_ovf_set", ovf, 1'b1);
    drain("t3_fill_zero");
    chk("t3_ovf_sticky", ovf, 1'b1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t3_ovf_clear", ovf, 1'b0);

    // Full FIFO, pop coincides with push
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({8'hC0 + 8'(i), 8'(i)});
      ddr_word(8'hC0 + 8'(i), 8'(i), 1'b0);
    end
    chk("t4_fill_full", fill, 4'd8);
    exp_q.push_back(16'hEE44);
    fclk = 1'b0; lanes = 8'h44;
    tick(4);
    fclk = 1'b1; lanes = 8'hEE;
    tick(4);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("t4_fill_kept", fill, 4'd8);
    chk("t4_no_ovf", ovf, 1'b0);
    drain("t4_fill_zero");

    // Reset in HAVE_LO with three buffered words
    for (int i = 0; i < 3; i++) ddr_word(8'h50 + 8'(i), 8'h60 + 8'(i), 1'b0);
    fclk = 1'b0; lanes = 8'h55;
    tick(5);
    rst = 1'b1; fclk = 1'b1; lanes = 8'h66;
    tick(1);
    chk("t5_valid", valid, 1'b0);
    chk("t5_fill", fill, 4'd0);
    chk("t5_link", link, 1'b0);
    rst = 1'b0;
    tick(10);
    chk("t5_no_word", fill, 4'd0);
    exp_q.push_back(16'h0FF0);
    ddr_word(8'h0F, 8'hF0, 1'b1);
    drain("t5_fill_zero");

    // SDR: 0x3C on rises, 0xC3 on falls, clk_div 4
    for (int i = 0; i < 6; i++) begin
      s_fclk = 1'b0; s_lanes = 8'hC3;
      tick(2);
      s_fclk = 1'b1; s_lanes = 8'h3C;
      s_q.push_back(8'h3C);
      tick(2);
    end
    tick(10);
    chk("t6_sdr_count", sdr_words, 6);
    chk("t6_sdr_fill", s_fill, 4'd0);

    chk("ddr_queue_empty", exp_q.size(), 0);
    chk("sdr_queue_empty", s_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
